// File: rtl/mips_cpu_bus_pkg.sv
// rtl/mips_cpu_bus_pkg.sv - shared types and helpers for the CPU Avalon bus path
package mips_cpu_bus_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      ERR,
      RESP
   } state_e;

   // Size 2'b11 is never legal; half and word must sit on their natural boundary.
   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: is_aligned = 1'b1;
         SIZE_HALF: is_aligned = ~off[0];
         SIZE_WORD: is_aligned = (off == 2'b00);
         default:   is_aligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mips_cpu_bus_lane_align.sv
// rtl/mips_cpu_bus_lane_align.sv - byte-lane enables, store shifting and load extension
module mips_cpu_bus_lane_align
   import mips_cpu_bus_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic        sgn,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  byteenable,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext
);

   logic [31:0] rdata_shift;

   assign rdata_shift = rdata >> {off, 3'b000};
   assign wdata_lane  = wdata << {off, 3'b000};

   always_comb begin
      byteenable = 4'b0000;
      rdata_ext  = 32'h0;
      case (size)
         SIZE_BYTE: begin
            byteenable = 4'b0001 << off;
            rdata_ext  = {{24{sgn & rdata_shift[7]}}, rdata_shift[7:0]};
         end
         SIZE_HALF: begin
            byteenable = 4'b0011 << off;
            rdata_ext  = {{16{sgn & rdata_shift[15]}}, rdata_shift[15:0]};
         end
         SIZE_WORD: begin
            byteenable = 4'b1111;
            rdata_ext  = rdata;
         end
         default: begin
            byteenable = 4'b0000;
            rdata_ext  = 32'h0;
         end
      endcase
   end

endmodule

// File: rtl/mips_cpu_avalon_master.sv
// rtl/mips_cpu_avalon_master.sv - single-outstanding Avalon-MM initiator for core loads/stores
module mips_cpu_avalon_master #(
   parameter int STALL_LIMIT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] address,
   output logic [3:0]  byteenable,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic        stall_timeout
);
   import mips_cpu_bus_pkg::*;

   localparam int CW = $clog2(STALL_LIMIT + 1);

   state_e        state, state_next;
   logic [CW-1:0] wait_cnt, wait_cnt_d;
   logic [1:0]    off_q, off_d, size_q, size_d;
   logic          sgn_q, sgn_d;
   logic [31:0]   address_d, writedata_d, resp_rdata_d;
   logic [3:0]    byteenable_d;
   logic          read_d, write_d, resp_valid_d, resp_err_d, stall_d;

   logic [1:0]    la_size, la_off;
   logic          la_sgn;
   logic [3:0]    la_be;
   logic [31:0]   la_wdata, la_rdata;

   assign req_ready = (state == IDLE);

   // One aligner serves both phases: request fields while idle, latched fields afterwards.
   assign la_size = (state == IDLE) ? req_size       : size_q;
   assign la_off  = (state == IDLE) ? req_addr[1:0]  : off_q;
   assign la_sgn  = (state == IDLE) ? req_signed     : sgn_q;

   mips_cpu_bus_lane_align u_align (
      .size       (la_size),
      .off        (la_off),
      .sgn        (la_sgn),
      .wdata      (req_wdata),
      .rdata      (readdata),
      .byteenable (la_be),
      .wdata_lane (la_wdata),
      .rdata_ext  (la_rdata)
   );

   always_comb begin
      state_next   = state;
      wait_cnt_d   = wait_cnt;
      off_d        = off_q;
      size_d       = size_q;
      sgn_d        = sgn_q;
      address_d    = address;
      byteenable_d = byteenable;
      writedata_d  = writedata;
      read_d       = read;
      write_d      = write;
      resp_valid_d = resp_valid;
      resp_err_d   = resp_err;
      resp_rdata_d = resp_rdata;
      stall_d      = stall_timeout;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (!is_aligned(req_size, req_addr[1:0])) begin
                  state_next = ERR;
               end else begin
                  address_d    = {req_addr[31:2], 2'b00};
                  byteenable_d = la_be;
                  writedata_d  = la_wdata;
                  read_d       = ~req_write;
                  write_d      = req_write;
                  off_d        = req_addr[1:0];
                  size_d       = req_size;
                  sgn_d        = req_signed;
                  state_next   = BUS;
               end
            end
         end
         BUS: begin
            if (waitrequest) begin
               if (wait_cnt != CW'(STALL_LIMIT))
                  wait_cnt_d = wait_cnt + CW'(1);
               if (wait_cnt >= CW'(STALL_LIMIT - 1))
                  stall_d = 1'b1;
            end else begin
               read_d       = 1'b0;
               write_d      = 1'b0;
               wait_cnt_d   = '0;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = read ? la_rdata : 32'h0;
               state_next   = RESP;
            end
         end
         ERR: begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
            state_next   = RESP;
         end
         RESP: begin
            resp_valid_d = 1'b0;
            resp_err_d   = 1'b0;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         off_q         <= 2'b00;
         size_q        <= 2'b00;
         sgn_q         <= 1'b0;
         address       <= 32'h0;
         byteenable    <= 4'b0000;
         writedata     <= 32'h0;
         read          <= 1'b0;
         write         <= 1'b0;
         resp_valid    <= 1'b0;
         resp_err      <= 1'b0;
         resp_rdata    <= 32'h0;
         stall_timeout <= 1'b0;
      end else begin
         state         <= state_next;
         wait_cnt      <= wait_cnt_d;
         off_q         <= off_d;
         size_q        <= size_d;
         sgn_q         <= sgn_d;
         address       <= address_d;
         byteenable    <= byteenable_d;
         writedata     <= writedata_d;
         read          <= read_d;
         write         <= write_d;
         resp_valid    <= resp_valid_d;
         resp_err      <= resp_err_d;
         resp_rdata    <= resp_rdata_d;
         stall_timeout <= stall_d;
      end
   end

endmodule
